// File: rtl/wheel_score_tracker.sv
// Turn-based multi-player score tracker for the spinning wheel game.
// Tracks per-player scores, rotates turns and ends the game on a win or after MAX_ROUNDS rounds.
module wheel_score_tracker #(
    parameter int NUM_PLAYERS = 4,
    parameter int SCORE_W     = 4,
    parameter int PTS_W       = 2,
    parameter int WIN_SCORE   = 12,
    parameter int MAX_ROUNDS  = 8,
    parameter int SATURATE    = 0,
    localparam int PLAYER_W   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int ROUND_W    = $clog2(MAX_ROUNDS + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           start,
    input  logic                           spin_valid,
    input  logic                           spin_bit,
    input  logic [PTS_W-1:0]               spin_points,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score_flat,
    output logic [PLAYER_W-1:0]            current_player,
    output logic [ROUND_W-1:0]             round_count,
    output logic                           busy,
    output logic                           done,
    output logic [PLAYER_W-1:0]            winner,
    output logic                           tie
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DONE
    } state_t;

    localparam int                 SUM_W       = SCORE_W + 1;
    localparam logic [31:0]        WIN_U       = 32'(WIN_SCORE);
    localparam logic [PLAYER_W-1:0] LAST_PLAYER = PLAYER_W'(NUM_PLAYERS - 1);
    localparam logic [ROUND_W-1:0] ROUND_LIMIT = ROUND_W'(MAX_ROUNDS);

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   score_q [NUM_PLAYERS];
    logic [SCORE_W-1:0]   score_d [NUM_PLAYERS];
    logic [PLAYER_W-1:0]  cur_q, cur_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic [PLAYER_W-1:0]  winner_q, winner_d;
    logic                 tie_q, tie_d;

    logic [SUM_W-1:0]     sum;
    logic [SCORE_W-1:0]   hit_score;
    logic [SCORE_W-1:0]   new_score;
    logic                 last_turn;
    logic [SCORE_W-1:0]   best;
    logic [PLAYER_W-1:0]  best_idx;
    logic                 dup;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        cur_d     = cur_q;
        round_d   = round_q;
        winner_d  = winner_q;
        tie_d     = tie_q;
        best      = '0;
        best_idx  = '0;
        dup       = 1'b0;

        // The sum carries one extra bit so saturation can see the overflow.
        sum       = SUM_W'(score_q[cur_q]) + SUM_W'(spin_points);
        if (SATURATE != 0) begin
            hit_score = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
        end else begin
            hit_score = sum[SCORE_W-1:0];
        end
        new_score = spin_bit ? score_q[cur_q] : hit_score;
        last_turn = (cur_q == LAST_PLAYER);

        case (state_q)
            IDLE, DONE: begin
                if (enable && start) begin
                    state_d = PLAY;
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        score_d[p] = '0;
                    end
                    cur_d    = '0;
                    round_d  = '0;
                    winner_d = '0;
                    tie_d    = 1'b0;
                end
            end
            PLAY: begin
                if (enable && spin_valid) begin
                    score_d[cur_q] = new_score;
                    cur_d = last_turn ? '0 : cur_q + PLAYER_W'(1);
                    if (last_turn) begin
                        round_d = round_q + ROUND_W'(1);
                    end
                    if (32'(new_score) >= WIN_U) begin
                        state_d  = DONE;
                        winner_d = cur_q;
                        tie_d    = 1'b0;
                    end else if (last_turn && (round_q + ROUND_W'(1) == ROUND_LIMIT)) begin
                        // Lowest index wins among equal maxima; any repeat of the maximum is a tie.
                        state_d  = DONE;
                        best     = score_d[0];
                        best_idx = '0;
                        dup      = 1'b0;
                        for (int p = 1; p < NUM_PLAYERS; p++) begin
                            if (score_d[p] > best) begin
                                best     = score_d[p];
                                best_idx = PLAYER_W'(p);
                                dup      = 1'b0;
                            end else if (score_d[p] == best) begin
                                dup = 1'b1;
                            end
                        end
                        winner_d = best_idx;
                        tie_d    = dup;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                score_q[p] <= '0;
            end
            cur_q    <= '0;
            round_q  <= '0;
            winner_q <= '0;
            tie_q    <= 1'b0;
        end else begin
            score_q  <= score_d;
            cur_q    <= cur_d;
            round_q  <= round_d;
            winner_q <= winner_d;
            tie_q    <= tie_d;
        end
    end

    always_comb begin
        score_flat = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            score_flat[p*SCORE_W +: SCORE_W] = score_q[p];
        end
    end

    assign current_player = cur_q;
    assign round_count    = round_q;
    assign winner         = winner_q;
    assign tie            = tie_q;
    assign busy           = (state_q == PLAY);
    assign done           = (state_q == DONE);

endmodule

// File: tb/tb_wheel_score_tracker.sv
// Self-checking bench: three tracker configurations share one stimulus stream
// and are compared every cycle against a game-rule model, plus directed literal checks.
module tb_wheel_score_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic       spin_valid = 1'b0;
    logic       spin_bit = 1'b0;
    logic [1:0] spin_points = 2'd0;

    logic [15:0] sf [3];
    logic [1:0]  cp [3];
    logic [3:0]  rc [3];
    logic        bz [3];
    logic        dn [3];
    logic [1:0]  wn [3];
    logic        tz [3];

    int checks = 0;
    int errors = 0;

    // Configuration 0: defaults; 1: wrap with win disabled; 2: saturate with win disabled.
    int cfg_sat [3] = '{0, 0, 1};
    int cfg_win [3] = '{12, 16, 16};

    // Model state: 0 = idle, 1 = playing, 2 = finished.
    int m_state  [3];
    int m_cur    [3];
    int m_round  [3];
    int m_winner [3];
    int m_tie    [3];
    int m_score  [3][4];

    wheel_score_tracker #(.WIN_SCORE(12), .SATURATE(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .spin_valid(spin_valid), .spin_bit(spin_bit), .spin_points(spin_points),
        .score_flat(sf[0]), .current_player(cp[0]), .round_count(rc[0]),
        .busy(bz[0]), .done(dn[0]), .winner(wn[0]), .tie(tz[0])
    );

    wheel_score_tracker #(.WIN_SCORE(16), .SATURATE(0)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .spin_valid(spin_valid), .spin_bit(spin_bit), .spin_points(spin_points),
        .score_flat(sf[1]), .current_player(cp[1]), .round_count(rc[1]),
        .busy(bz[1]), .done(dn[1]), .winner(wn[1]), .tie(tz[1])
    );

    wheel_score_tracker #(.WIN_SCORE(16), .SATURATE(1)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .spin_valid(spin_valid), .spin_bit(spin_bit), .spin_points(spin_points),
        .score_flat(sf[2]), .current_player(cp[2]), .round_count(rc[2]),
        .busy(bz[2]), .done(dn[2]), .winner(wn[2]), .tie(tz[2])
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelClear(input int c);
        for (int p = 0; p < 4; p++) m_score[c][p] = 0;
        m_cur[c]    = 0;
        m_round[c]  = 0;
        m_winner[c] = 0;
        m_tie[c]    = 0;
    endtask

    task automatic modelStep();
        int s;
        int was;
        int mx;
        int cnt;
        for (int c = 0; c < 3; c++) begin
            if (!enable) continue;
            if (m_state[c] != 1) begin
                if (start) begin
                    modelClear(c);
                    m_state[c] = 1;
                end
            end else if (spin_valid) begin
                was = m_cur[c];
                if (!spin_bit) begin
                    s = m_score[c][was] + int'(spin_points);
                    if (cfg_sat[c] != 0) s = (s > 15) ? 15 : s;
                    else s = s % 16;
                    m_score[c][was] = s;
                end
                m_cur[c] = (was + 1) % 4;
                if (was == 3) m_round[c] = m_round[c] + 1;
                if (m_score[c][was] >= cfg_win[c]) begin
                    m_state[c]  = 2;
                    m_winner[c] = was;
                    m_tie[c]    = 0;
                end else if (was == 3 && m_round[c] == 8) begin
                    m_state[c] = 2;
                    mx = 0;
                    for (int p = 0; p < 4; p++) if (m_score[c][p] > mx) mx = m_score[c][p];
                    cnt = 0;
                    m_winner[c] = -1;
                    for (int p = 0; p < 4; p++) begin
                        if (m_score[c][p] == mx) begin
                            cnt++;
                            if (m_winner[c] < 0) m_winner[c] = p;
                        end
                    end
                    m_tie[c] = (cnt > 1) ? 1 : 0;
                end
            end
        end
    endtask

    initial begin
        for (int c = 0; c < 3; c++) begin
            m_state[c] = 0;
            modelClear(c);
        end
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int c = 0; c < 3; c++) begin
                    m_state[c] = 0;
                    modelClear(c);
                end
            end else begin
                modelStep();
            end
        end
    end

    // Every falling edge: all outputs of every configuration against the model.
    initial begin
        logic [15:0] exp;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                exp = '0;
                for (int p = 0; p < 4; p++) exp[p*4 +: 4] = 4'(m_score[c][p]);
                checkOutput($sformatf("cfg%0d score_flat", c), 32'(sf[c]), 32'(exp));
                checkOutput($sformatf("cfg%0d current_player", c), 32'(cp[c]), 32'(m_cur[c]));
                checkOutput($sformatf("cfg%0d round_count", c), 32'(rc[c]), 32'(m_round[c]));
                checkOutput($sformatf("cfg%0d busy", c), 32'(bz[c]), (m_state[c] == 1) ? 1 : 0);
                checkOutput($sformatf("cfg%0d done", c), 32'(dn[c]), (m_state[c] == 2) ? 1 : 0);
                checkOutput($sformatf("cfg%0d winner", c), 32'(wn[c]), 32'(m_winner[c]));
                checkOutput($sformatf("cfg%0d tie", c), 32'(tz[c]), 32'(m_tie[c]));
            end
        end
    end

    // One clock edge with the given inputs; returns just after that edge.
    task automatic applyStimulus(input logic st, input logic sv, input logic sb, input logic [1:0] pts);
        @(negedge clk);
        #1;
        start       = st;
        spin_valid  = sv;
        spin_bit    = sb;
        spin_points = pts;
        @(posedge clk);
        #1;
        start      = 1'b0;
        spin_valid = 1'b0;
    endtask

    task automatic doSpin(input logic hit, input logic [1:0] pts);
        applyStimulus(1'b0, 1'b1, ~hit, pts);
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #12;
        reset  = 1'b0;
        enable = 1'b1;
        checkOutput("reset score_flat", 32'(sf[0]), 0);
        checkOutput("reset busy", 32'(bz[0]), 0);
        checkOutput("reset done", 32'(dn[0]), 0);

        // Player 1 hits 3 every turn: wins with 12 on the 14th spin.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 14; i++) doSpin((i % 4) == 1, 2'd3);
        checkOutput("t1 done", 32'(dn[0]), 1);
        checkOutput("t1 winner", 32'(wn[0]), 1);
        checkOutput("t1 tie", 32'(tz[0]), 0);
        checkOutput("t1 round_count", 32'(rc[0]), 3);
        checkOutput("t1 current_player", 32'(cp[0]), 2);
        checkOutput("t1 score_flat", 32'(sf[0]), 32'h00C0);
        for (int i = 0; i < 4; i++) doSpin(1'b1, 2'd3);
        checkOutput("t1 frozen score_flat", 32'(sf[0]), 32'h00C0);
        checkOutput("t1 frozen current_player", 32'(cp[0]), 2);

        // Two single hits then misses: round limit with a tie between players 0 and 2.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 32; i++) begin
            doSpin(i == 0 || i == 2, 2'd1);
            if (i == 30) checkOutput("t2 not done early", 32'(dn[0]), 0);
        end
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("t2 cfg%0d score_flat", c), 32'(sf[c]), 32'h0101);
            checkOutput($sformatf("t2 cfg%0d done", c), 32'(dn[c]), 1);
            checkOutput($sformatf("t2 cfg%0d round_count", c), 32'(rc[c]), 8);
            checkOutput($sformatf("t2 cfg%0d winner", c), 32'(wn[c]), 0);
            checkOutput($sformatf("t2 cfg%0d tie", c), 32'(tz[c]), 1);
        end

        // Player 0 climbs to 14 then takes +3: wraps to 1 or clamps at 15.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        for (int r = 0; r < 7; r++) begin
            for (int p = 0; p < 4; p++) begin
                doSpin(p == 0, (r == 4) ? 2'd2 : 2'd3);
                if (p == 0 && r == 5) begin
                    checkOutput("t3 wrap score", 32'(sf[1][3:0]), 1);
                    checkOutput("t3 wrap done", 32'(dn[1]), 0);
                    checkOutput("t3 sat score", 32'(sf[2][3:0]), 15);
                end
                if (p == 0 && r == 6) begin
                    checkOutput("t3 sat held", 32'(sf[2][3:0]), 15);
                    checkOutput("t3 sat done", 32'(dn[2]), 0);
                end
            end
        end

        // Asynchronous reset between edges, then a lone spin before start.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) doSpin(1'b1, 2'd2);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("t4 async score_flat", 32'(sf[0]), 0);
        checkOutput("t4 async busy", 32'(bz[0]), 0);
        checkOutput("t4 async current_player", 32'(cp[0]), 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        doSpin(1'b1, 2'd2);
        checkOutput("t4 spin ignored busy", 32'(bz[0]), 0);
        checkOutput("t4 spin ignored score", 32'(sf[0]), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        checkOutput("t4 start busy", 32'(bz[0]), 1);

        // Enable gating, start ignored while playing, restart from done.
        doSpin(1'b1, 2'd1);
        enable = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);
        checkOutput("t5 gated current_player", 32'(cp[0]), 1);
        checkOutput("t5 gated score_flat", 32'(sf[0]), 32'h0001);
        enable = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        checkOutput("t5 start in play busy", 32'(bz[0]), 1);
        checkOutput("t5 start in play current_player", 32'(cp[0]), 1);
        for (int n = 0; n < 40 && m_state[0] != 2; n++) doSpin(m_cur[0] == 0, 2'd3);
        checkOutput("t5 reached done", 32'(dn[0]), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        checkOutput("t5 restart score_flat", 32'(sf[0]), 0);
        checkOutput("t5 restart busy", 32'(bz[0]), 1);
        checkOutput("t5 restart done", 32'(dn[0]), 0);
        checkOutput("t5 restart current_player", 32'(cp[0]), 0);

        // Random traffic, occasional mid-cycle resets.
        doReset();
        for (int n = 0; n < 800; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 299) == 0) begin
                @(posedge clk);
                #2;
                reset = 1'b1;
                #4;
                reset = 1'b0;
            end
            applyStimulus($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wheel_score_tracker.md
Name: wheel_score_tracker

Overview:
Multi-player, parametrised successor to the single-player wheel score counter. Up to NUM_PLAYERS players spin in turn. Each accepted spin result updates only the current player's score, using either wrap-around or saturating arithmetic. A small game FSM ends the game on the first player to reach WIN_SCORE, or after MAX_ROUNDS full rounds, and reports the winner and any tie to the game controller / display logic.

Parameters:
NUM_PLAYERS, 4, number of players (2..16); PLAYER_W = max(1, clog2(NUM_PLAYERS)) is derived locally
SCORE_W, 4, bits per player score
PTS_W, 2, bits of spin_points
WIN_SCORE, 12, score at or above which the current player wins immediately (may exceed 2^SCORE_W-1, i.e. disabled)
MAX_ROUNDS, 8, full rounds before forced end (>=1)
SATURATE, 0, 0 = score wraps modulo 2^SCORE_W; 1 = score clamps at 2^SCORE_W-1

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
enable  in  1  global qualifier; spins and start are ignored while low
start  in  1  begin a new game (sampled at clk)
spin_valid  in  1  one spin result present this cycle
spin_bit  in  1  spin outcome; 0 = hit, 1 = miss
spin_points  in  PTS_W  points awarded on a hit
score_flat  out  NUM_PLAYERS*SCORE_W  player p occupies bits [p*SCORE_W +: SCORE_W]
current_player  out  PLAYER_W  player whose spin is awaited
round_count  out  clog2(MAX_ROUNDS+1)  completed full rounds
busy  out  1  state == PLAY
done  out  1  state == DONE
winner  out  PLAYER_W  winning player; valid while done
tie  out  1  done by round limit with more than one player at the max score

Behaviour:
- States: IDLE, PLAY, DONE. Every output is registered or a pure decode of state.
- Reset (async, any state, mid-game included): IDLE, all scores 0, current_player 0, round_count 0, winner 0, tie 0, busy 0, done 0.
- IDLE:
  - start && enable -> PLAY on the next edge.
  - On the same edge, clear scores, current_player, round_count, winner and tie.
- PLAY, spin acceptance:
  - A spin is accepted on an edge with spin_valid && enable; exactly one spin is consumed per accepting edge.
  - The updated score and advanced turn are visible the cycle after that edge (latency 1).
  - start is ignored in PLAY.
- PLAY, score update on an accepted spin:
  - Hit: new = score[cur] + spin_points, computed at SCORE_W+1 bits.
  - SATURATE=0: result is new mod 2^SCORE_W.
  - SATURATE=1: result is min(new, 2^SCORE_W-1).
  - Miss, or spin_points = 0: score unchanged; the turn still advances.
  - Only score[cur] may change.
- PLAY, turn advance: current_player increments. On the player NUM_PLAYERS-1 spin it returns to 0 and round_count increments.
- PLAY, termination (evaluated on the accepting edge using the post-update score):
  - Priority 1, win: updated score[cur] >= WIN_SCORE -> DONE, winner = cur, tie = 0.
  - Priority 2, round limit: else, if cur = NUM_PLAYERS-1 and round_count+1 = MAX_ROUNDS -> DONE.
    - winner = lowest-index player holding the maximum updated score.
    - tie = 1 if two or more players hold that maximum.
  - Priority 1 wins when both conditions hold on the same spin.
  - done asserts the cycle after the final accepting edge.
  - On entering DONE, current_player and round_count take their advanced values and then freeze.
- DONE:
  - Scores, winner and tie are held.
  - Spins are ignored.
  - start && enable restarts exactly as from IDLE (clear, then PLAY).
- enable low freezes all state; a start or spin_valid pulse during that time is lost, not queued.

Test Plan:
1. Defaults. Start; player 1 hits with 3 points every turn, all others miss -> player 1 score 3,6,9,12; done after player 1's 4th spin (14th spin overall), winner=1, tie=0, round_count=3, current_player=2; later spins change nothing.
2. Defaults. Player 0 hits +1 once, player 2 hits +1 once, all else miss for 32 spins -> done after spin 32, round_count=8, winner=0, tie=1; score_flat = 0x0101 (player 0 = 1 in bits 3:0, player 2 = 1 in bits 11:8).
3. SATURATE=0, WIN_SCORE=16: drive player 0 to 14, then a hit of 3 -> score 1, not done. SATURATE=1, same stimulus -> score 15, then stays 15 on further hits.
4. Mid-game, assert reset asynchronously between clock edges -> all outputs 0 and IDLE immediately, without waiting for clk; after release, one spin_valid pulse is ignored until start.
5. In PLAY: spin_valid with enable=0 -> no score or turn change. start during PLAY -> ignored. From DONE, start -> scores cleared, busy=1, done=0, current_player=0 the next cycle.
